// File: rtl/drive_sequencer_pkg.sv
// ============================================================================
// drive_sequencer_pkg : shared state, nav_cmd, motor and LED encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package drive_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_DRIVE   = 3'd0,
    ST_BRAKE   = 3'd1,
    ST_REVERSE = 3'd2,
    ST_TURN    = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  localparam logic [1:0] NAV_STOP  = 2'b00;
  localparam logic [1:0] NAV_FWD   = 2'b01;
  localparam logic [1:0] NAV_LEFT  = 2'b10;
  localparam logic [1:0] NAV_RIGHT = 2'b11;

  // Motor word is {l_en, l_dir, r_en, r_dir}
  localparam logic [3:0] MOT_STOP  = 4'b0000;
  localparam logic [3:0] MOT_FWD   = 4'b1111;
  localparam logic [3:0] MOT_LEFT  = 4'b1011;
  localparam logic [3:0] MOT_RIGHT = 4'b1110;
  localparam logic [3:0] MOT_REV   = 4'b1010;

  localparam logic [2:0] LED_DRIVE  = 3'b001;
  localparam logic [2:0] LED_ESCAPE = 3'b010;
  localparam logic [2:0] LED_FAULT  = 3'b100;

  function automatic logic [3:0] nav_to_motor(input logic [1:0] nav);
    logic [3:0] m;
    case (nav)
      NAV_FWD:   m = MOT_FWD;
      NAV_LEFT:  m = MOT_LEFT;
      NAV_RIGHT: m = MOT_RIGHT;
      default:   m = MOT_STOP;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/drive_sequencer_seq_timer.sv
// ============================================================================
// seq_timer : loadable down-counter, done when the count reaches zero
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/drive_sequencer.sv
// ============================================================================
// drive_sequencer : passes nav commands to the motors, runs a timed
// brake/reverse/turn escape on collision and latches FAULT on repeated failure
// Rev 1.0
// ============================================================================
`default_nettype none

module drive_sequencer
  import drive_sequencer_pkg::*;
#(
  parameter int BRAKE_CYC = 5_000_000,
  parameter int REV_CYC   = 25_000_000,
  parameter int TURN_CYC  = 20_000_000,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       col_detect,
  input  logic [1:0] nav_cmd,
  output logic       motor_l_en,
  output logic       motor_l_dir,
  output logic       motor_r_en,
  output logic       motor_r_dir,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state_led
);

  localparam logic [CNT_W-1:0] BRAKE_LD = CNT_W'(BRAKE_CYC - 1);
  localparam logic [CNT_W-1:0] REV_LD   = CNT_W'(REV_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYC - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [2:0]       retry_q, retry_d;
  logic [3:0]       motor_q, motor_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic [2:0]       led_q, led_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_done;

  seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .done     (tmr_done)
  );

  // Next-state and retry bookkeeping
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      ST_DRIVE: begin
        if (col_detect) state_d = ST_BRAKE;
      end
      ST_BRAKE: begin
        if (tmr_done) state_d = ST_REVERSE;
      end
      ST_REVERSE: begin
        if (tmr_done) state_d = ST_TURN;
      end
      ST_TURN: begin
        if (tmr_done) begin
          if (!col_detect) begin
            state_d = ST_DRIVE;
            retry_d = '0;
          end else if (retry_q < RETRY_MAX) begin
            state_d = ST_BRAKE;
            retry_d = (retry_q == 3'b111) ? retry_q : retry_q + 3'd1;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (!col_detect && nav_cmd == NAV_STOP) begin
          state_d = ST_DRIVE;
          retry_d = '0;
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // Every state entry reloads the timer, so it can never underflow mid-phase
  always_comb begin
    tmr_load     = (state_d != state_q);
    tmr_load_val = '0;
    case (state_d)
      ST_BRAKE:   tmr_load_val = BRAKE_LD;
      ST_REVERSE: tmr_load_val = REV_LD;
      ST_TURN:    tmr_load_val = TURN_LD;
      default:    tmr_load_val = '0;
    endcase
  end

  // Outputs decoded from the next state so they register alongside it
  always_comb begin
    motor_d = MOT_STOP;
    busy_d  = 1'b1;
    fault_d = 1'b0;
    led_d   = LED_ESCAPE;
    case (state_d)
      ST_DRIVE: begin
        motor_d = nav_to_motor(nav_cmd);
        busy_d  = 1'b0;
        led_d   = LED_DRIVE;
      end
      ST_BRAKE:   motor_d = MOT_STOP;
      ST_REVERSE: motor_d = MOT_REV;
      ST_TURN:    motor_d = MOT_RIGHT;
      default: begin
        motor_d = MOT_STOP;
        fault_d = 1'b1;
        led_d   = LED_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DRIVE;
      retry_q <= '0;
      motor_q <= MOT_STOP;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      led_q   <= LED_DRIVE;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      motor_q <= motor_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      led_q   <= led_d;
    end
  end

  assign {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir} = motor_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign state_led = led_q;

endmodule

`default_nettype wire

// File: tb/tb_drive_sequencer.sv
// ============================================================================
// tb_drive_sequencer : directed vectors and escape/fault/reset sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       col_detect;
  logic [1:0] nav_cmd;
  logic       motor_l_en, motor_l_dir, motor_r_en, motor_r_dir;
  logic       busy, fault;
  logic [2:0] state_led;

  int n_tests = 0;
  int n_fail  = 0;

  drive_sequencer #(
    .BRAKE_CYC (4),
    .REV_CYC   (8),
    .TURN_CYC  (6),
    .MAX_RETRY (2),
    .CNT_W     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col_detect  (col_detect),
    .nav_cmd     (nav_cmd),
    .motor_l_en  (motor_l_en),
    .motor_l_dir (motor_l_dir),
    .motor_r_en  (motor_r_en),
    .motor_r_dir (motor_r_dir),
    .busy        (busy),
    .fault       (fault),
    .state_led   (state_led)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       col;
    logic [1:0] nav;
    logic [3:0] mot;
    logic       busy;
    logic       fault;
    logic [2:0] led;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic col, input logic [1:0] nav, input logic [3:0] mot,
                     input logic b, input logic f, input logic [2:0] led);
    vec_t v;
    v.col = col; v.nav = nav; v.mot = mot; v.busy = b; v.fault = f; v.led = led;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] mot, input logic b,
                       input logic f, input logic [2:0] led);
    logic [8:0] act, exp;
    act = {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir, busy, fault, state_led};
    exp = {mot, b, f, led};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got mot/busy/fault/led=%b_%b_%b_%b want %b_%b_%b_%b",
               name, act[8:5], act[4], act[3], act[2:0], exp[8:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  // Apply inputs at the falling edge, clock once, sample at the next falling edge
  task automatic step(input logic col, input logic [1:0] nav);
    col_detect = col;
    nav_cmd    = nav;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Collision held high from DRIVE: three full escapes, then FAULT
  task automatic escape_to_fault(input string tag);
    for (int a = 0; a < 3; a++) begin
      for (int c = 0; c < 18; c++) begin
        step(1'b1, 2'b01);
        if (c < 4)       check({tag, "_brake"}, 4'b0000, 1'b1, 1'b0, 3'b010);
        else if (c < 12) check({tag, "_rev"},   4'b1010, 1'b1, 1'b0, 3'b010);
        else             check({tag, "_turn"},  4'b1110, 1'b1, 1'b0, 3'b010);
      end
    end
    step(1'b1, 2'b01);
    check({tag, "_fault"}, 4'b0000, 1'b1, 1'b1, 3'b100);
  endtask

  initial begin
    // Basic drive, collision priority, escape with col pulses in REVERSE, recovery
    add(1'b0, 2'b01, 4'b1111, 1'b0, 1'b0, 3'b001);
    add(1'b0, 2'b10, 4'b1011, 1'b0, 1'b0, 3'b001);
    add(1'b0, 2'b11, 4'b1110, 1'b0, 1'b0, 3'b001);
    add(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 3'b001);
    add(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 3'b010);
    for (int i = 0; i < 3; i++) add(1'b0, 2'b01, 4'b0000, 1'b1, 1'b0, 3'b010);
    for (int i = 0; i < 8; i++)
      add((i == 2 || i == 4) ? 1'b1 : 1'b0, 2'b01, 4'b1010, 1'b1, 1'b0, 3'b010);
    for (int i = 0; i < 6; i++) add(1'b0, 2'b11, 4'b1110, 1'b1, 1'b0, 3'b010);
    add(1'b0, 2'b10, 4'b1011, 1'b0, 1'b0, 3'b001);
    add(1'b0, 2'b01, 4'b1111, 1'b0, 1'b0, 3'b001);

    rst = 1'b1;
    col_detect = 1'b0;
    nav_cmd = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_state", 4'b0000, 1'b0, 1'b0, 3'b001);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].col, vecs[i].nav);
      check($sformatf("vec%0d", i), vecs[i].mot, vecs[i].busy, vecs[i].fault, vecs[i].led);
    end

    escape_to_fault("hold1");
    step(1'b0, 2'b01);
    check("fault_hold_nav01", 4'b0000, 1'b1, 1'b1, 3'b100);
    step(1'b1, 2'b00);
    check("fault_hold_col1", 4'b0000, 1'b1, 1'b1, 3'b100);
    step(1'b0, 2'b00);
    check("fault_exit", 4'b0000, 1'b0, 1'b0, 3'b001);
    step(1'b0, 2'b01);
    check("drive_after_fault", 4'b1111, 1'b0, 1'b0, 3'b001);

    // Retry count must have been cleared: another full three attempts before FAULT
    escape_to_fault("hold2");
    step(1'b0, 2'b00);
    check("fault_exit2", 4'b0000, 1'b0, 1'b0, 3'b001);

    // Async reset in the middle of TURN
    step(1'b1, 2'b01);
    for (int i = 0; i < 13; i++) step(1'b0, 2'b01);
    check("in_turn", 4'b1110, 1'b1, 1'b0, 3'b010);
    #2 rst = 1'b1;
    #1 check("async_rst_now", 4'b0000, 1'b0, 1'b0, 3'b001);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2'b10);
    check("after_rst_left", 4'b1011, 1'b0, 1'b0, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
